// File: rtl/pwm_preconditioner.sv
`default_nettype none
// ============================================================================
// Module      : pwm_preconditioner
// Description : Converts filtered duty/phase into PWM rise/fall edge times per
//               transducer via a serial 2-stage pipeline; atomic commit.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_preconditioner #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [DEPTH-1:0][WIDTH-1:0]  cycle,
  input  logic [DEPTH-1:0][WIDTH-1:0]  duty_s,
  input  logic [DEPTH-1:0][WIDTH-1:0]  phase_s,
  output logic [DEPTH-1:0][WIDTH-1:0]  rise,
  output logic [DEPTH-1:0][WIDTH-1:0]  fall,
  output logic                         out_valid,
  output logic                         busy
);

  localparam int SW = WIDTH + 2;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic [IW-1:0]        c_last = IW'(DEPTH - 1);
  localparam logic signed [SW-1:0] c_one  = SW'(1);

  logic [1:0]                    state_q, state_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic                          flush_q, flush_d;
  logic                          pending_q, pending_d;
  logic                          out_valid_q, out_valid_d;
  logic [DEPTH-1:0][WIDTH-1:0]   cyc_sh_q, cyc_sh_d;
  logic [DEPTH-1:0][WIDTH-1:0]   duty_sh_q, duty_sh_d;
  logic [DEPTH-1:0][WIDTH-1:0]   phase_sh_q, phase_sh_d;
  logic [DEPTH-1:0][WIDTH-1:0]   work_rise_q, work_rise_d;
  logic [DEPTH-1:0][WIDTH-1:0]   work_fall_q, work_fall_d;
  logic [DEPTH-1:0][WIDTH-1:0]   rise_q, rise_d;
  logic [DEPTH-1:0][WIDTH-1:0]   fall_q, fall_d;

  logic                          s1_valid_q, s1_valid_d;
  logic [IW-1:0]                 s1_idx_q, s1_idx_d;
  logic signed [SW-1:0]          s1_r0_q, s1_r0_d;
  logic signed [SW-1:0]          s1_f0_q, s1_f0_d;
  logic [WIDTH-1:0]              s1_c_q, s1_c_d;
  logic [WIDTH-1:0]              s1_p_q, s1_p_d;
  logic                          s1_cz_q, s1_cz_d;
  logic                          s1_dz_q, s1_dz_d;
  logic                          s1_full_q, s1_full_d;

  logic                          snap;
  logic                          feed;

  // Control FSM
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    flush_d     = flush_q;
    pending_d   = pending_q;
    out_valid_d = 1'b0;
    rise_d      = rise_q;
    fall_d      = fall_q;
    snap        = 1'b0;
    feed        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          snap    = 1'b1;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        feed      = 1'b1;
        pending_d = pending_q | in_valid;
        if (idx_q == c_last) begin
          flush_d = 1'b0;
          state_d = S_FLUSH;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_FLUSH: begin
        pending_d = pending_q | in_valid;
        flush_d   = 1'b1;
        if (flush_q) state_d = S_COMMIT;
      end
      default: begin
        rise_d      = work_rise_q;
        fall_d      = work_fall_q;
        out_valid_d = 1'b1;
        // A request arriving during the commit cycle itself still earns a pass
        if (pending_q || in_valid) begin
          pending_d = 1'b0;
          snap      = 1'b1;
          idx_d     = '0;
          state_d   = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    cyc_sh_d   = snap ? cycle   : cyc_sh_q;
    duty_sh_d  = snap ? duty_s  : duty_sh_q;
    phase_sh_d = snap ? phase_s : phase_sh_q;
  end

  // Stage 1: phase reduction, duty clamp, raw edges
  always_comb begin
    logic signed [SW-1:0] c_s, d_s, p_s, pa, da;
    c_s = $signed({2'b00, cyc_sh_q[idx_q]});
    d_s = $signed({2'b00, duty_sh_q[idx_q]});
    p_s = $signed({2'b00, phase_sh_q[idx_q]});
    pa  = (p_s >= c_s) ? (p_s - c_s) : p_s;
    da  = (d_s > c_s) ? c_s : d_s;
    s1_valid_d = feed;
    s1_idx_d   = idx_q;
    s1_r0_d    = pa - (da >>> 1);
    s1_f0_d    = pa + ((da + c_one) >>> 1);
    s1_c_d     = cyc_sh_q[idx_q];
    s1_p_d     = WIDTH'(pa);
    s1_cz_d    = (c_s == '0);
    s1_dz_d    = (d_s == '0);
    s1_full_d  = (d_s >= c_s);
  end

  // Stage 2: wrap correction and special cases into the working arrays
  always_comb begin
    logic signed [SW-1:0] c_e, r_w, f_w;
    logic [WIDTH-1:0]     r_v, f_v;
    c_e = $signed({2'b00, s1_c_q});
    r_w = s1_r0_q[SW-1] ? (s1_r0_q + c_e) : s1_r0_q;
    f_w = (s1_f0_q >= c_e) ? (s1_f0_q - c_e) : s1_f0_q;
    if (s1_cz_q) begin
      r_v = '0;
      f_v = '0;
    end else if (s1_dz_q) begin
      r_v = s1_p_q;
      f_v = s1_p_q;
    end else if (s1_full_q) begin
      r_v = '0;
      f_v = s1_c_q;
    end else begin
      r_v = WIDTH'(r_w);
      f_v = WIDTH'(f_w);
    end
    work_rise_d = work_rise_q;
    work_fall_d = work_fall_q;
    if (s1_valid_q) begin
      work_rise_d[s1_idx_q] = r_v;
      work_fall_d[s1_idx_q] = f_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      flush_q     <= 1'b0;
      pending_q   <= 1'b0;
      out_valid_q <= 1'b0;
      cyc_sh_q    <= '0;
      duty_sh_q   <= '0;
      phase_sh_q  <= '0;
      work_rise_q <= '0;
      work_fall_q <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s1_r0_q     <= '0;
      s1_f0_q     <= '0;
      s1_c_q      <= '0;
      s1_p_q      <= '0;
      s1_cz_q     <= 1'b0;
      s1_dz_q     <= 1'b0;
      s1_full_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      flush_q     <= flush_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      cyc_sh_q    <= cyc_sh_d;
      duty_sh_q   <= duty_sh_d;
      phase_sh_q  <= phase_sh_d;
      work_rise_q <= work_rise_d;
      work_fall_q <= work_fall_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      s1_valid_q  <= s1_valid_d;
      s1_idx_q    <= s1_idx_d;
      s1_r0_q     <= s1_r0_d;
      s1_f0_q     <= s1_f0_d;
      s1_c_q      <= s1_c_d;
      s1_p_q      <= s1_p_d;
      s1_cz_q     <= s1_cz_d;
      s1_dz_q     <= s1_dz_d;
      s1_full_q   <= s1_full_d;
    end
  end

  assign rise      = rise_q;
  assign fall      = fall_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pwm_preconditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_preconditioner
// Description : Table-driven scoreboard bench for pwm_preconditioner (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_preconditioner;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [3:0][12:0]  cycle, duty_s, phase_s;
  logic [3:0][12:0]  rise, fall;
  logic              out_valid, busy;

  pwm_preconditioner #(.WIDTH(13), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .cycle(cycle), .duty_s(duty_s), .phase_s(phase_s),
    .rise(rise), .fall(fall), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][12:0] c, d, p, r, f;
  } vec_t;

  typedef struct {
    logic [3:0][12:0] r, f;
    int               due;
  } exp_t;

  vec_t             vecs [4];
  exp_t             sb [$];
  int               cyc = 0;
  int               n_checks = 0;
  int               n_err = 0;
  logic [3:0][12:0] last_r = '0;
  logic [3:0][12:0] last_f = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Output monitor: commits are popped from the scoreboard; otherwise outputs must hold
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", 64'(cyc), 64'(e.due));
          chk("rise", 64'(rise), 64'(e.r));
          chk("fall", 64'(fall), 64'(e.f));
          last_r = e.r;
          last_f = e.f;
        end
      end else begin
        chk("stable_rise", 64'(rise), 64'(last_r));
        chk("stable_fall", 64'(fall), 64'(last_f));
      end
    end
  end

  task automatic pulse(input int vi, output int k);
    @(posedge clk); #1;
    cycle    = vecs[vi].c;
    duty_s   = vecs[vi].d;
    phase_s  = vecs[vi].p;
    in_valid = 1'b1;
    k        = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_pass(input int vi, input int due);
    exp_t e;
    e.r   = vecs[vi].r;
    e.f   = vecs[vi].f;
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int k, k2;
    vecs[0].c = {4{13'd4096}};
    vecs[0].d = {4{13'd2048}};
    vecs[0].p = {4{13'd0}};
    vecs[0].r = {4{13'd3072}};
    vecs[0].f = {4{13'd1024}};

    vecs[1].c = {4{13'd4096}};
    vecs[1].d = {4{13'd1001}};
    vecs[1].p = {13'd100,  13'd0,    13'd5000, 13'd4000};
    vecs[1].r = {13'd3696, 13'd3596, 13'd404,  13'd3500};
    vecs[1].f = {13'd601,  13'd501,  13'd1405, 13'd405};

    vecs[2].c = {13'd4096, 13'd4096, 13'd4096, 13'd0};
    vecs[2].d = {13'd5000, 13'd4096, 13'd0,    13'd100};
    vecs[2].p = {13'd3,    13'd10,   13'd77,   13'd50};
    vecs[2].r = {13'd0,    13'd0,    13'd77,   13'd0};
    vecs[2].f = {13'd4096, 13'd4096, 13'd77,   13'd0};

    vecs[3].c = {13'd10,   13'd1000, 13'd8191, 13'd100};
    vecs[3].d = {13'd0,    13'd999,  13'd8190, 13'd1};
    vecs[3].p = {13'd15,   13'd1500, 13'd8190, 13'd99};
    vecs[3].r = {13'd5,    13'd1,    13'd4095, 13'd99};
    vecs[3].f = {13'd5,    13'd0,    13'd4094, 13'd0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    cycle    = '0;
    duty_s   = '0;
    phase_s  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_rise", 64'(rise), 64'd0);
    chk("reset_fall", 64'(fall), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    // Single passes over every table vector
    for (int i = 0; i < 4; i++) begin
      pulse(i, k);
      expect_pass(i, k + 8);
      chk("busy_after_start", 64'(busy), 64'd1);
      drain();
      chk("idle_after_commit", 64'(busy), 64'd0);
    end

    // Second request two cycles into a pass
    pulse(0, k);
    expect_pass(0, k + 8);
    pulse(1, k2);
    expect_pass(1, k + 15);
    wait_until(k + 7);
    @(negedge clk);
    chk("busy_through_commit", 64'(busy), 64'd1);
    drain();

    // Three requests while busy merge into one extra pass
    pulse(2, k);
    expect_pass(2, k + 8);
    pulse(3, k2);
    pulse(3, k2);
    pulse(3, k2);
    expect_pass(3, k + 15);
    drain();
    repeat (20) @(posedge clk);
    #1;

    // Request landing exactly in the commit cycle
    pulse(0, k);
    expect_pass(0, k + 8);
    wait_until(k + 6);
    pulse(1, k2);
    chk("commit_cycle_req_cyc", 64'(k2), 64'(k + 7));
    expect_pass(1, k + 15);
    drain();

    // Reset in the middle of a run
    pulse(2, k);
    @(posedge clk); #1;
    rst_n  = 1'b0;
    last_r = '0;
    last_f = '0;
    #1;
    chk("midrun_reset_rise", 64'(rise), 64'd0);
    chk("midrun_reset_fall", 64'(fall), 64'd0);
    chk("midrun_reset_out_valid", 64'(out_valid), 64'd0);
    chk("midrun_reset_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("post_reset_idle", 64'(busy), 64'd0);
    pulse(3, k);
    expect_pass(3, k + 8);
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
